// File: rtl/spi_sensor_responder_pkg.sv
// Shared constants, state encoding and register read mux for the sensor SPI responder.
package spi_sensor_responder_pkg;

   localparam int unsigned CMD_BITS   = 8;
   localparam int unsigned DATA_BITS  = 16;
   localparam int unsigned FRAME_BITS = CMD_BITS + DATA_BITS;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned CMD_RW_BIT = 7;

   localparam logic [ADDR_W-1:0] ADDR_TEMP   = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_CONFIG = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_ID     = 7'h02;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      DATA    = 2'd2,
      WAIT_CS = 2'd3
   } state_t;

   // Register file read view; unmapped addresses read as zero.
   function automatic logic [DATA_BITS-1:0] read_mux(
      input logic [ADDR_W-1:0]    addr,
      input logic [DATA_BITS-1:0] temp,
      input logic [DATA_BITS-1:0] cfg,
      input logic [DATA_BITS-1:0] id
   );
      logic [DATA_BITS-1:0] val;
      val = '0;
      case (addr)
         ADDR_TEMP:   val = temp;
         ADDR_CONFIG: val = cfg;
         ADDR_ID:     val = id;
         default:     val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/spi_sensor_responder_sync.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_neg,
   input  logic din,
   output logic sync,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Synchroniser chain plus one delayed copy of the synced level for edge detection.
   always_ff @(posedge clk or negedge rst_neg) begin
      if (!rst_neg) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign sync   = chain[STAGES-1];
   assign rise_c = sync & ~prev;
   assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_sensor_responder.sv
// Mode-0 SPI slave emulating the temperature sensor: 8-bit command + 16-bit data frames.
module spi_sensor_responder
   import spi_sensor_responder_pkg::*;
#(
   parameter logic [15:0] DEVICE_ID    = 16'h0190,
   parameter logic [15:0] CONFIG_RESET = 16'h0000,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_neg,
   input  logic        sck_sensor,
   input  logic        cs_sensor,
   input  logic        mosi_sensor,
   output logic        miso_sensor,
   input  logic [15:0] temp_value,
   output logic [15:0] config_reg,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        busy
);

   logic sck_sync_unused;
   logic sck_rise;
   logic sck_fall;
   logic cs_s;
   logic cs_rise;
   logic cs_fall;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_chain;

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [CMD_BITS-2:0]     cmd_sh;
   logic [DATA_BITS-2:0]    rx_sh;
   logic [DATA_BITS-1:0]    tx_sh;
   logic [ADDR_W-1:0]       addr;
   logic                    is_read;

   logic [CMD_BITS-1:0]     cmd_next;
   logic [DATA_BITS-1:0]    rx_next;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk    (clk),
      .rst_neg(rst_neg),
      .din    (sck_sensor),
      .sync   (sck_sync_unused),
      .rise_c (sck_rise),
      .fall_c (sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst_neg(rst_neg),
      .din    (cs_sensor),
      .sync   (cs_s),
      .rise_c (cs_rise),
      .fall_c (cs_fall)
   );

   // mosi only needs a level synchroniser, same depth as sck so data stays aligned with edges.
   always_ff @(posedge clk or negedge rst_neg) begin
      if (!rst_neg) begin
         mosi_chain <= '0;
      end else begin
         mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi_sensor};
      end
   end

   assign mosi_s   = mosi_chain[SYNC_STAGES-1];
   assign cmd_next = {cmd_sh, mosi_s};
   assign rx_next  = {rx_sh, mosi_s};

   // Frame FSM: command shift/decode, data shift in/out, config commit and frame status pulses.
   always_ff @(posedge clk or negedge rst_neg) begin
      if (!rst_neg) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         cmd_sh      <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         addr        <= '0;
         is_read     <= 1'b0;
         miso_sensor <= 1'b0;
         config_reg  <= CONFIG_RESET;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            IDLE: begin
               miso_sensor <= 1'b0;
               if (cs_fall) begin
                  state   <= CMD;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            CMD: begin
               miso_sensor <= 1'b0;
               if (cs_rise) begin
                  state       <= IDLE;
                  frame_abort <= 1'b1;
                  busy        <= 1'b0;
               end else if (sck_rise) begin
                  cmd_sh  <= cmd_next[CMD_BITS-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                     is_read <= cmd_next[CMD_RW_BIT];
                     addr    <= cmd_next[ADDR_W-1:0];
                     tx_sh   <= read_mux(cmd_next[ADDR_W-1:0], temp_value, config_reg, DEVICE_ID);
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (cs_rise) begin
                  state       <= IDLE;
                  frame_abort <= 1'b1;
                  busy        <= 1'b0;
                  miso_sensor <= 1'b0;
               end else if (sck_fall) begin
                  miso_sensor <= is_read & tx_sh[DATA_BITS-1] & ~cs_s;
                  tx_sh       <= {tx_sh[DATA_BITS-2:0], 1'b0};
               end else if (sck_rise) begin
                  rx_sh   <= rx_next[DATA_BITS-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                     if (!is_read && addr == ADDR_CONFIG) begin
                        config_reg <= rx_next;
                     end
                     state       <= WAIT_CS;
                     busy        <= 1'b0;
                     miso_sensor <= 1'b0;
                  end
               end
            end
            WAIT_CS: begin
               miso_sensor <= 1'b0;
               if (cs_rise) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               miso_sensor <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: vector table of frames plus reset/overrun sequences.
module tb_spi_sensor_responder;

   logic        clk;
   logic        rst_neg;
   logic        sck_sensor;
   logic        cs_sensor;
   logic        mosi_sensor;
   logic        miso_sensor;
   logic [15:0] temp_value;
   logic [15:0] config_reg;
   logic        frame_done;
   logic        frame_abort;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;

   spi_sensor_responder dut (
      .clk        (clk),
      .rst_neg    (rst_neg),
      .sck_sensor (sck_sensor),
      .cs_sensor  (cs_sensor),
      .mosi_sensor(mosi_sensor),
      .miso_sensor(miso_sensor),
      .temp_value (temp_value),
      .config_reg (config_reg),
      .frame_done (frame_done),
      .frame_abort(frame_abort),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Count one-cycle status pulses.
   always @(negedge clk) begin
      if (frame_done)  done_cnt++;
      if (frame_abort) abort_cnt++;
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] data;
      logic [15:0] temp;
      int          nbits;
      int          chg_at;
      logic [15:0] chg_temp;
      logic        chk_miso;
      logic [15:0] exp_miso;
      logic [15:0] exp_cfg;
      int          exp_done;
      int          exp_abort;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One SPI master frame, sck half period = 4 clk; miso sampled just before each rise.
   task automatic spi_frame(input string tag, input logic [7:0] cmd, input logic [15:0] data,
                            input int nbits, input int extra, input int chg_at,
                            input logic [15:0] chg_temp, input int rst_at,
                            output logic [15:0] mw);
      logic [23:0] bits;
      bit          stop;
      bits = {cmd, data};
      mw   = '0;
      stop = 1'b0;
      sck_sensor = 1'b0;
      cs_sensor  = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 1; k <= nbits && !stop; k++) begin
         mosi_sensor = bits[24-k];
         repeat (4) @(negedge clk);
         if (k >= 9) mw = {mw[14:0], miso_sensor};
         if (k == chg_at) temp_value = chg_temp;
         if (k == rst_at) begin
            rst_neg = 1'b0;
            #1;
            chk({tag, " rst cfg"},   32'(config_reg),  32'h0000);
            chk({tag, " rst busy"},  32'(busy),        32'h0);
            chk({tag, " rst miso"},  32'(miso_sensor), 32'h0);
            chk({tag, " rst done"},  32'(frame_done),  32'h0);
            chk({tag, " rst abort"}, 32'(frame_abort), 32'h0);
            stop = 1'b1;
         end else begin
            sck_sensor = 1'b1;
            repeat (4) @(negedge clk);
            if (k == 1) chk({tag, " busy in frame"}, 32'(busy), 32'h1);
            sck_sensor = 1'b0;
         end
      end
      if (stop) begin
         sck_sensor = 1'b0;
         cs_sensor  = 1'b1;
         repeat (4) @(negedge clk);
         rst_neg = 1'b1;
         repeat (4) @(negedge clk);
         return;
      end
      for (int e = 0; e < extra; e++) begin
         mosi_sensor = e[0];
         repeat (4) @(negedge clk);
         chk($sformatf("%s extra%0d miso", tag, e), 32'(miso_sensor), 32'h0);
         sck_sensor = 1'b1;
         repeat (4) @(negedge clk);
         sck_sensor = 1'b0;
      end
      repeat (4) @(negedge clk);
      if (nbits == 24) chk({tag, " busy after 24"}, 32'(busy), 32'h0);
      cs_sensor = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic [15:0] mw;
      int          d0;
      int          a0;

      vecs[0] = '{8'h80, 16'h0000, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'h0A5C, 16'h0000, 1, 0};
      vecs[1] = '{8'h01, 16'hBEEF, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, 1, 0};
      vecs[2] = '{8'h81, 16'h0000, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1, 0};
      vecs[3] = '{8'h82, 16'h0000, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'h0190, 16'hBEEF, 1, 0};
      vecs[4] = '{8'h85, 16'h0000, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, 1, 0};
      vecs[5] = '{8'h00, 16'h1234, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, 1, 0};
      vecs[6] = '{8'h01, 16'h1111, 16'h0A5C, 23, 0, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 0, 1};
      vecs[7] = '{8'h81, 16'h0000, 16'h0A5C, 24, 0, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1, 0};
      vecs[8] = '{8'h80, 16'h0000, 16'h0100, 24, 12, 16'h0200, 1'b1, 16'h0100, 16'hBEEF, 1, 0};
      vecs[9] = '{8'h80, 16'h0000, 16'h0200, 24, 0, 16'h0000, 1'b1, 16'h0200, 16'hBEEF, 1, 0};

      rst_neg     = 1'b0;
      cs_sensor   = 1'b1;
      sck_sensor  = 1'b0;
      mosi_sensor = 1'b0;
      temp_value  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset cfg",   32'(config_reg),  32'h0000);
      chk("reset miso",  32'(miso_sensor), 32'h0);
      chk("reset busy",  32'(busy),        32'h0);
      chk("reset done",  32'(frame_done),  32'h0);
      chk("reset abort", 32'(frame_abort), 32'h0);
      rst_neg = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         temp_value = vecs[i].temp;
         d0 = done_cnt;
         a0 = abort_cnt;
         spi_frame(tag, vecs[i].cmd, vecs[i].data, vecs[i].nbits, 0,
                   vecs[i].chg_at, vecs[i].chg_temp, 0, mw);
         if (vecs[i].chk_miso) chk({tag, " miso word"}, 32'(mw), 32'(vecs[i].exp_miso));
         chk({tag, " cfg"},   32'(config_reg),     32'(vecs[i].exp_cfg));
         chk({tag, " done"},  32'(done_cnt - d0),  32'(vecs[i].exp_done));
         chk({tag, " abort"}, 32'(abort_cnt - a0), 32'(vecs[i].exp_abort));
      end

      // Reset in the data phase of a config write: no partial commit, back to reset value.
      d0 = done_cnt;
      spi_frame("rstmid", 8'h01, 16'h5555, 24, 0, 0, 16'h0000, 16, mw);
      chk("rstmid cfg after",  32'(config_reg),    32'h0000);
      chk("rstmid no done",    32'(done_cnt - d0), 32'h0);

      // 28 sck pulses: the write commits on rise 24, the rest are ignored.
      d0 = done_cnt;
      a0 = abort_cnt;
      spi_frame("over", 8'h01, 16'h00FF, 24, 4, 0, 16'h0000, 0, mw);
      chk("over cfg",   32'(config_reg),     32'h00FF);
      chk("over done",  32'(done_cnt - d0),  32'h1);
      chk("over abort", 32'(abort_cnt - a0), 32'h0);
      chk("over miso",  32'(miso_sensor),    32'h0);

      spi_frame("rdback", 8'h81, 16'h0000, 24, 0, 0, 16'h0000, 0, mw);
      chk("rdback miso word", 32'(mw), 32'h00FF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
